// File: rtl/clm_multiplier.sv
// clm_multiplier: GF(2) carry-less W x W polynomial multiply, reduced mod P via the MC table.
// Latency: drdy_i sampled at edge N -> drdy_o pulses after edge N+W+1; fixed, operand independent.
// Backpressure: none; drdy_i while BUSY is dropped, never queued. Optional masking: CLM_MUL_MASK_EN.
module clm_multiplier #(
  parameter int D = 8,
  localparam int W = 8 + D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         drdy_i,
  input  logic [W-1:0] p1,
  input  logic [W-1:0] p2,
  input  logic [W-1:0] random_vect [0:2*W-1],
  input  logic [W-1:0] MC [0:W-2],
  output logic [W-1:0] out,
  output logic         drdy_o
);

  localparam int AW = 2*W - 1;
  localparam int IW = $clog2(W);
  localparam int KW = $clog2(W + 1);
  localparam logic [KW-1:0] K_LAST = KW'(W);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [AW-1:0] acc;
  logic [W-1:0]  p1_q;
  logic [W-1:0]  p2_q;
  logic [W-1:0]  mc_q [0:W-2];
  logic [IW-1:0] k_idx;
  logic [W-1:0]  mask_word;
  logic [AW-1:0] pp;
  logic [W-1:0]  red;

  // k runs 0..W; only the low bits address operand bits and mask words while k < W.
  assign k_idx = k[IW-1:0];

`ifdef CLM_MUL_MASK_EN
  logic [W-1:0] r_q [0:2*W-1];

  // Mask contribution for cycle k: the pair r[2k], r[2k+1] folded together.
  always_comb mask_word = r_q[{k_idx, 1'b0}] ^ r_q[{k_idx, 1'b1}];
`else
  logic unused_random;

  // Mask words are accepted on the port but have no effect in this build.
  always_comb begin
    unused_random = 1'b0;
    for (int i = 0; i < 2*W; i++) unused_random = unused_random ^ (^random_vect[i]);
  end

  assign mask_word = '0;
`endif

  // Partial product for cycle k: p1 shifted up by k when coefficient p2[k] is set.
  always_comb begin
    pp = '0;
    if (p2_q[k_idx]) pp = {{(W-1){1'b0}}, p1_q} << k_idx;
  end

  // Fold the high half of the accumulator back using the precomputed x^(W+j) mod P rows.
  always_comb begin
    red = acc[W-1:0];
    for (int j = 0; j < W-1; j++) begin
      if (acc[W+j]) red = red ^ mc_q[j];
    end
  end

  // Control FSM plus datapath: latch on start, W accumulate cycles, one reduce/emit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      k      <= '0;
      acc    <= '0;
      out    <= '0;
      drdy_o <= 1'b0;
    end else begin
      drdy_o <= 1'b0;
      case (state)
        IDLE: begin
          if (drdy_i) begin
            p1_q <= p1;
            p2_q <= p2;
            for (int j = 0; j < W-1; j++) mc_q[j] <= MC[j];
`ifdef CLM_MUL_MASK_EN
            for (int i = 0; i < 2*W; i++) r_q[i] <= random_vect[i];
`endif
            acc   <= '0;
            k     <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (k == K_LAST) begin
            out    <= red;
            drdy_o <= 1'b1;
            state  <= IDLE;
          end else begin
            acc <= acc ^ pp ^ {{(W-1){1'b0}}, mask_word};
            k   <= k + KW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clm_multiplier.sv
// tb_clm_multiplier: directed bench for clm_multiplier with a result scoreboard.
// Expected values come from a long-division GF(2) model against the full modulus P.
// Modulus stands in for p_det=11: P = (x^8+x^4+x^3+x+1)*(x^8+x^3+x+1).
`timescale 1ns/1ps
module tb_clm_multiplier;

  localparam int D  = 8;
  localparam int W  = 8 + D;
  localparam int AW = 2*W - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         drdy_i;
  logic [W-1:0] p1, p2;
  logic [W-1:0] random_vect [0:2*W-1];
  logic [W-1:0] MC [0:W-2];
  logic [W-1:0] out;
  logic         drdy_o;

  typedef struct { logic [W-1:0] dat; int due; } exp_t;
  exp_t exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [W:0]   p_mod;
  logic [W-1:0] mc_tab [0:W-2];

  clm_multiplier #(.D(D)) dut (
    .clk(clk), .rst(rst), .drdy_i(drdy_i), .p1(p1), .p2(p2),
    .random_vect(random_vect), .MC(MC), .out(out), .drdy_o(drdy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [AW-1:0] clmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [AW-1:0] t;
    t = '0;
    for (int i = 0; i < W; i++) if (b[i]) t = t ^ ({{(W-1){1'b0}}, a} << i);
    return t;
  endfunction

  function automatic logic [W-1:0] mod_p(input logic [AW-1:0] v);
    logic [AW-1:0] t;
    t = v;
    for (int i = AW-1; i >= W; i--) if (t[i]) t = t ^ ({{(W-2){1'b0}}, p_mod} << (i - W));
    return t[W-1:0];
  endfunction

  function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] m;
    m = '0;
`ifdef CLM_MUL_MASK_EN
    for (int i = 0; i < 2*W; i++) m = m ^ random_vect[i];
`endif
    return mod_p(clmul(a, b) ^ {{(W-1){1'b0}}, m});
  endfunction

  // Scoreboard: every drdy_o pulse must match the oldest outstanding request, value and cycle.
  always @(negedge clk) begin
    if (drdy_o === 1'b1) begin
      n_cmp++;
      assert (exp_q.size() > 0)
        else begin n_bad++; $error("FAIL spurious_drdy_o observed=1 expected=0 cyc=%0d", cyc); end
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_cmp++;
        assert (out === e.dat)
          else begin n_bad++; $error("FAIL result observed=%h expected=%h", out, e.dat); end
        n_cmp++;
        assert (cyc === e.due)
          else begin n_bad++; $error("FAIL latency observed_cyc=%0d expected_cyc=%0d", cyc, e.due); end
      end
    end
  end

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] e);
    exp_t x;
    p1 = a; p2 = b; drdy_i = 1'b1;
    x.dat = e;
    x.due = cyc + W + 2;
    exp_q.push_back(x);
    @(posedge clk); #1;
    drdy_i = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    assert (exp_q.size() === 0)
      else begin n_bad++; $error("FAIL %s_timeout observed_pending=%0d expected=0", tag, exp_q.size()); end
    exp_q.delete();
  endtask

  initial begin
    logic [W-1:0] a, b, e;
    logic [W-1:0] mc_save;
    logic [8:0]   f_poly, r_poly;

    f_poly = 9'h11B;
    r_poly = 9'h10B;
    p_mod  = '0;
    for (int i = 0; i < 9; i++) if (r_poly[i]) p_mod = p_mod ^ ({8'b0, f_poly} << i);
    for (int j = 0; j < W-1; j++) begin
      mc_tab[j] = mod_p(AW'(1) << (W + j));
      MC[j]     = mc_tab[j];
    end
    for (int i = 0; i < 2*W; i++) random_vect[i] = '0;
    rst = 1'b1; drdy_i = 1'b0; p1 = '0; p2 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    assert (out === '0) else begin n_bad++; $error("FAIL reset_out observed=%h expected=0000", out); end
    n_cmp++;
    assert (drdy_o === 1'b0) else begin n_bad++; $error("FAIL reset_drdy observed=%b expected=0", drdy_o); end
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero operand, identity operand, top-degree products
    start_op(16'h0000, 16'h8000, 16'h0000); wait_done("zero");
    start_op(16'h0001, 16'h1234, 16'h1234); wait_done("identity");
    start_op(16'h8000, 16'h0002, mc_tab[0]); wait_done("x16");
    start_op(16'h8000, 16'h8000, mc_tab[14]); wait_done("x30");

    // Single mask word
    random_vect[0] = 16'h00FF;
`ifdef CLM_MUL_MASK_EN
    start_op(16'h0003, 16'h0005, 16'h00F0);
`else
    start_op(16'h0003, 16'h0005, 16'h000F);
`endif
    wait_done("mask");
    random_vect[0] = '0;

    // Random operands and masks; inputs scrambled right after the start edge
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 2*W; i++) random_vect[i] = W'($urandom);
      a = W'($urandom); b = W'($urandom);
      start_op(a, b, model(a, b));
      mc_save = MC[3];
      MC[3] = ~MC[3];
      p1 = W'($urandom); p2 = W'($urandom);
      for (int i = 0; i < 2*W; i++) random_vect[i] = W'($urandom);
      wait_done("random");
      MC[3] = mc_save;
    end

    // Back-to-back: new start in the cycle drdy_o is high
    a = W'($urandom); b = W'($urandom);
    start_op(a, b, model(a, b));
    repeat (W + 1) @(posedge clk);
    #1;
    n_cmp++;
    assert (drdy_o === 1'b1) else begin n_bad++; $error("FAIL b2b_drdy observed=%b expected=1", drdy_o); end
    a = W'($urandom); b = W'($urandom);
    start_op(a, b, model(a, b));
    wait_done("b2b");

    // Re-pulse during BUSY is ignored
    start_op(16'h00A5, 16'h0F0F, model(16'h00A5, 16'h0F0F));
    repeat (5) @(posedge clk);
    #1;
    p1 = 16'hFFFF; p2 = 16'hFFFF; drdy_i = 1'b1;
    @(posedge clk); #1;
    drdy_i = 1'b0;
    wait_done("busy_repulse");
    repeat (W + 4) @(posedge clk);

    // Abort mid-operation; reset wins over a simultaneous drdy_i
    start_op(16'h1357, 16'h2468, model(16'h1357, 16'h2468));
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1; drdy_i = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; drdy_i = 1'b0;
    exp_q.delete();
    n_cmp++;
    assert (out === '0) else begin n_bad++; $error("FAIL abort_out observed=%h expected=0000", out); end
    n_cmp++;
    assert (drdy_o === 1'b0) else begin n_bad++; $error("FAIL abort_drdy observed=%b expected=0", drdy_o); end
    repeat (W + 8) @(posedge clk);
    #1;
    n_cmp++;
    assert (out === '0) else begin n_bad++; $error("FAIL abort_hold observed=%h expected=0000", out); end
    start_op(16'hC001, 16'h0033, model(16'hC001, 16'h0033));
    wait_done("after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clm_multiplier.md
CLM_MULTIPLIER -- requirements
Module: clm_multiplier

Interface
REQ-001 The module SHALL have parameter D, default 8, meaning the redundancy degree; W = 8+D is the redundant polynomial width (16 by default).
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The module SHALL have port drdy_i, input, 1 bit: start strobe that samples p1, p2, random_vect and MC.
REQ-005 The module SHALL have port p1, input, W bits: operand polynomial over GF(2), bit i is the coefficient of x^i.
REQ-006 The module SHALL have port p2, input, W bits: operand polynomial, same encoding as p1.
REQ-007 The module SHALL have port random_vect, input, 2W entries of W bits: mask words r[0..2W-1].
REQ-008 The module SHALL have port MC, input, W-1 rows of W bits: row j = x^(W+j) mod P, where P = f(x)·R(x) is the degree-W modulus selected upstream by p_det.
REQ-009 The module SHALL have port out, output, W bits: registered result.
REQ-010 The module SHALL have port drdy_o, output, 1 bit: one-cycle result-valid pulse.

Function
REQ-011 The module SHALL have two states: IDLE and BUSY; out and drdy_o SHALL be the only outputs.
REQ-012 In IDLE, drdy_i=1 at an edge SHALL latch p1, p2, random_vect and MC, clear the accumulator (2W-1 bits) and cycle counter k, and enter BUSY.
REQ-013 In BUSY, on cycle k (0..W-1), the accumulator SHALL be XORed with (p1 << k) if p2[k]=1, and k SHALL increment.
REQ-014 With masking compiled in, cycle k SHALL also XOR (r[2k] ^ r[2k+1]) into accumulator bits [W-1:0].
REQ-015 After cycle W-1, the next edge SHALL reduce the accumulator: out = acc[W-1:0] XOR (XOR over j=0..W-2 of MC[j] where acc[W+j]=1).
REQ-016 That same edge SHALL pulse drdy_o high for exactly one cycle and return the state to IDLE.
REQ-017 Latency SHALL be fixed: drdy_i sampled at edge N gives drdy_o=1 after edge N+W+1 (17 cycles for D=8), independent of operand values.
REQ-018 out SHALL hold its value until the next completed operation; it SHALL NOT change during BUSY.
REQ-019 The result SHALL equal (p1·p2 + mask sum) mod P computed over GF(2); there SHALL be no carries.
REQ-020 drdy_i asserted during BUSY SHALL be ignored; no queueing of requests SHALL occur.
REQ-021 drdy_i held high across multiple IDLE edges SHALL start one operation per IDLE entry.
REQ-022 Back-to-back operation SHALL be supported: drdy_i=1 in the cycle drdy_o=1 starts a new operation.
REQ-023 Operand or MC changes after the start edge SHALL NOT affect the running operation.

Reset
REQ-024 rst=1 at an edge SHALL force state IDLE, k=0, accumulator=0, out=0 and drdy_o=0.
REQ-025 rst SHALL take priority over drdy_i.
REQ-026 rst asserted mid-operation SHALL abort the operation without emitting drdy_o.
REQ-027 After rst deasserts, the first drdy_i SHALL start a clean operation.

Configuration
REQ-028 The macro CLM_MUL_MASK_EN SHALL control masking.
REQ-029 When CLM_MUL_MASK_EN is defined, REQ-014 SHALL apply.
REQ-030 When CLM_MUL_MASK_EN is undefined, random_vect SHALL be accepted but ignored, and out = p1·p2 mod P exactly.
REQ-031 Port list and latency SHALL be identical in both builds.

Verification
REQ-032 The bench SHALL check: p1=0x0000, p2=0x8000, all r=0, MC from p_det=11, drdy_i pulsed one cycle -> drdy_o pulses after 17 cycles, out=0x0000.
REQ-033 The bench SHALL check: p1=0x0001, p2=0x1234, r=0 -> out=0x1234.
REQ-034 The bench SHALL check: p1=0x8000, p2=0x0002, r=0 -> product x^16, out=MC[0]; also p1=p2=0x8000 -> out=MC[14].
REQ-035 The bench SHALL check: r[0]=0x00FF, other r=0, p1=0x0003, p2=0x0005 -> out=0x000F^0x00FF=0x00F0 with CLM_MUL_MASK_EN, and out=0x000F without it.
REQ-036 The bench SHALL check: drdy_i re-pulsed at cycle 5 of BUSY -> ignored, single drdy_o with the first result.
REQ-037 The bench SHALL check: rst asserted at cycle 8 of BUSY -> no drdy_o, out=0; a new request then completes normally in 17 cycles.
